// File: rtl/mem_access_unit.sv
// MEM-stage load/store alignment unit: big-endian byte/half/word access to a word-wide memory,
// sub-word stores as a stalled read-modify-write. Optional MEM_ACCESS_ERR_COUNT_EN adds o_err_count.
module mem_access_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_load_valid,
  output logic              o_align_err,
  output logic              o_stall,
  output logic              o_dbg_state
`ifdef MEM_ACCESS_ERR_COUNT_EN
  ,
  output logic [15:0]       o_err_count
`endif
);

  // Handshake: i_req is valid-only. o_stall is the inverse of ready; while it is 1
  // upstream must hold i_req and every operand unchanged for the following cycle.

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_merge;
  logic [ADDR_W-3:0]   r_addr;
  logic [DATA_W-1:0]   r_load_data;
  logic                r_load_valid;
  logic                r_align_err;

  logic                w_aligned;
  logic                w_is_load;
  logic                w_is_word_st;
  logic                w_is_sub_st;
  logic                w_err;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load_ext;
  logic [DATA_W-1:0]   w_merge;

  always_comb begin
    w_aligned = 1'b0;
    case (i_size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~i_addr[0];
      2'b10:   w_aligned = (i_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_is_load    = i_req & ~i_we & w_aligned;
  assign w_is_word_st = i_req & i_we & w_aligned & (i_size == 2'b10);
  assign w_is_sub_st  = i_req & i_we & w_aligned & ~i_size[1];
  assign w_err        = i_req & ~w_aligned;

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr[1:0])
      2'b00:   w_byte = i_mem_rdata[31:24];
      2'b01:   w_byte = i_mem_rdata[23:16];
      2'b10:   w_byte = i_mem_rdata[15:8];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_mem_rdata[15:0] : i_mem_rdata[31:16];
  end

  always_comb begin
    w_load_ext = i_mem_rdata;
    case (i_size)
      2'b00:   w_load_ext = {{(DATA_W-8){i_sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = {{(DATA_W-16){i_sign_ext & w_half[15]}}, w_half};
      default: w_load_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = i_mem_rdata;
    if (i_size == 2'b00) begin
      case (i_addr[1:0])
        2'b00:   w_merge[31:24] = i_wdata[7:0];
        2'b01:   w_merge[23:16] = i_wdata[7:0];
        2'b10:   w_merge[15:8]  = i_wdata[7:0];
        default: w_merge[7:0]   = i_wdata[7:0];
      endcase
    end else if (i_addr[1]) begin
      w_merge[15:0] = i_wdata[15:0];
    end else begin
      w_merge[31:16] = i_wdata[15:0];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // Memory-side outputs are gated by reset so a write strobe never survives reset assertion.
  always_comb begin
    w_next_state = r_state;
    o_mem_addr   = i_addr[ADDR_W-1:2];
    o_mem_wdata  = i_wdata;
    o_mem_write  = 1'b0;
    o_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        o_mem_write = w_is_word_st & i_reset_n;
        o_stall     = w_is_sub_st & i_reset_n;
        if (w_is_sub_st) w_next_state = RMW_WRITE;
      end
      RMW_WRITE: begin
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_merge;
        o_mem_write  = i_reset_n;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_align_err  <= 1'b0;
      r_merge      <= '0;
      r_addr       <= '0;
    end else begin
      r_load_valid <= 1'b0;
      r_align_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (w_is_load) begin
          r_load_data  <= w_load_ext;
          r_load_valid <= 1'b1;
        end
        if (w_err) r_align_err <= 1'b1;
        if (w_is_sub_st) begin
          r_merge <= w_merge;
          r_addr  <= i_addr[ADDR_W-1:2];
        end
      end
    end
  end

`ifdef MEM_ACCESS_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                            r_err_count <= 16'h0000;
    else if (r_align_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'h0001;
  end

  assign o_err_count = r_err_count;
`endif

  assign o_load_data  = r_load_data;
  assign o_load_valid = r_load_valid;
  assign o_align_err  = r_align_err;
  assign o_dbg_state  = (r_state == RMW_WRITE);

endmodule
